// File: rtl/acb_pkg.sv
// Shared widths, field positions and FSM state type
// for the accelerator memory responder.
package acb_pkg;

   localparam int REQ_W       = 110;
   localparam int RSP_W       = 65;
   localparam int ADDR_W      = 36;
   localparam int REQ_LOCK    = 109;
   localparam int REQ_RD      = 108;
   localparam int REQ_MASK_HI = 107;
   localparam int REQ_MASK_LO = 100;
   localparam int REQ_ADDR_HI = 99;
   localparam int REQ_ADDR_LO = 64;
   localparam int REQ_DATA_HI = 63;
   localparam int RSP_ERR     = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESPOND
   } acb_state_e;

endpackage

// File: rtl/acb_mem_array.sv
// Single-port 64-bit RAM with byte write mask and
// registered read port; contents are never reset.
module acb_mem_array #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_mask,
   input  logic [63:0]       i_wdata,
   output logic [63:0]       o_rdata
);

   logic [63:0] r_mem [2**ADDR_W];
   logic [63:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_en && i_we) begin
         for (int i = 0; i < 8; i++) begin
            if (i_mask[i]) begin
               r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
      end
      if (i_en && !i_we) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/acb_mem_responder.sv
// Request/response memory responder: accept, wait
// ACCESS_LATENCY cycles, then hold the response.
module acb_mem_responder
   import acb_pkg::*;
#(
   parameter int MEM_ADDR_W     = 8,
   parameter int ACCESS_LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ACB_MEM_REQUEST_pipe_write_req,
   output logic             ACB_MEM_REQUEST_pipe_write_ack,
   input  logic [REQ_W-1:0] ACB_MEM_REQUEST_pipe_write_data,
   input  logic             ACB_MEM_RESPONSE_pipe_read_req,
   output logic             ACB_MEM_RESPONSE_pipe_read_ack,
   output logic [RSP_W-1:0] ACB_MEM_RESPONSE_pipe_read_data,
   output logic [7:0]       err_count
);

   acb_state_e              r_state;
   acb_state_e              w_next;
   logic [3:0]              r_cnt;
   logic                    r_rd;
   logic                    r_err;
   logic [7:0]              r_mask;
   logic [MEM_ADDR_W-1:0]   r_idx;
   logic [63:0]             r_wdata;
   logic [RSP_W-1:0]        r_rsp;
   logic [7:0]              r_err_cnt;

   logic                    w_wr_ack;
   logic                    w_rd_ack;
   logic                    w_req_xfer;
   logic                    w_last;
   logic [ADDR_W-1:0]       w_in_addr;
   logic [MEM_ADDR_W-1:0]   w_in_idx;
   logic                    w_in_err;
   logic                    w_in_rd;
   logic                    w_ram_rd;
   logic                    w_ram_wr;
   logic [MEM_ADDR_W-1:0]   w_ram_addr;
   logic [63:0]             w_rdata;

   assign w_in_addr = ACB_MEM_REQUEST_pipe_write_data[REQ_ADDR_HI:REQ_ADDR_LO];
   assign w_in_idx  = w_in_addr[MEM_ADDR_W+2:3];
   assign w_in_err  = |w_in_addr[ADDR_W-1:MEM_ADDR_W+3];
   assign w_in_rd   = ACB_MEM_REQUEST_pipe_write_data[REQ_RD];

   assign w_req_xfer = w_wr_ack && ACB_MEM_REQUEST_pipe_write_req;
   assign w_last     = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

   // Reads launch at acceptance so the registered RAM
   // output is ready even when the latency is one cycle.
   assign w_ram_rd   = w_req_xfer && w_in_rd && !w_in_err;
   assign w_ram_wr   = w_last && !r_rd && !r_err;
   assign w_ram_addr = (r_state == ST_IDLE) ? w_in_idx : r_idx;

   acb_mem_array #(
      .ADDR_W (MEM_ADDR_W)
   ) u_mem (
      .clk     (clk),
      .i_en    (w_ram_rd || w_ram_wr),
      .i_we    (w_ram_wr),
      .i_addr  (w_ram_addr),
      .i_mask  (r_mask),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_next   = r_state;
      w_wr_ack = 1'b0;
      w_rd_ack = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_wr_ack = 1'b1;
            if (ACB_MEM_REQUEST_pipe_write_req) w_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (r_cnt == 4'd0) w_next = ST_RESPOND;
         end
         ST_RESPOND: begin
            w_rd_ack = 1'b1;
            if (ACB_MEM_RESPONSE_pipe_read_req) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_rd      <= 1'b0;
         r_err     <= 1'b0;
         r_mask    <= 8'h00;
         r_idx     <= '0;
         r_wdata   <= 64'h0;
         r_rsp     <= '0;
         r_err_cnt <= 8'h00;
      end else begin
         r_state <= w_next;
         if (w_req_xfer) begin
            r_cnt   <= 4'(ACCESS_LATENCY - 1);
            r_rd    <= w_in_rd;
            r_err   <= w_in_err;
            r_mask  <= ACB_MEM_REQUEST_pipe_write_data[REQ_MASK_HI:REQ_MASK_LO];
            r_idx   <= w_in_idx;
            r_wdata <= ACB_MEM_REQUEST_pipe_write_data[REQ_DATA_HI:0];
         end else if (r_state == ST_ACCESS && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_last) begin
            if (r_err)     r_rsp <= {1'b1, 64'h0};
            else if (r_rd) r_rsp <= {1'b0, w_rdata};
            else           r_rsp <= '0;
            if (r_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign ACB_MEM_REQUEST_pipe_write_ack  = w_wr_ack;
   assign ACB_MEM_RESPONSE_pipe_read_ack  = w_rd_ack;
   assign ACB_MEM_RESPONSE_pipe_read_data = r_rsp;
   assign err_count                       = r_err_cnt;

endmodule

// File: tb/tb_acb_mem_responder.sv
// Directed bench for acb_mem_responder with default
// parameters (MEM_ADDR_W=8, ACCESS_LATENCY=2).
module tb_acb_mem_responder;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_req;
   logic          wr_ack;
   logic [109:0]  wr_data;
   logic          rd_req;
   logic          rd_ack;
   logic [64:0]   rd_data;
   logic [7:0]    err_count;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] W1 = 64'h1122334455667788;
   localparam logic [63:0] W2 = 64'h11223344556677FF;
   localparam logic [63:0] W3 = 64'hAAAA55550F0FF0F0;
   localparam logic [63:0] W4 = 64'hCAFEF00D12345678;

   acb_mem_responder dut (
      .clk                             (clk),
      .reset                           (reset),
      .ACB_MEM_REQUEST_pipe_write_req  (wr_req),
      .ACB_MEM_REQUEST_pipe_write_ack  (wr_ack),
      .ACB_MEM_REQUEST_pipe_write_data (wr_data),
      .ACB_MEM_RESPONSE_pipe_read_req  (rd_req),
      .ACB_MEM_RESPONSE_pipe_read_ack  (rd_ack),
      .ACB_MEM_RESPONSE_pipe_read_data (rd_data),
      .err_count                       (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [64:0] obs,
                      input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full request/response exchange, timed in cycles.
   task automatic do_req(input logic rd, input logic [7:0] m,
                         input logic [35:0] a, input logic [63:0] d,
                         input logic lk, output logic [64:0] resp,
                         output int lat);
      int n;
      @(negedge clk);
      wr_req  = 1'b1;
      wr_data = {lk, rd, m, a, d};
      n = 0;
      while (!wr_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      wr_req = 1'b0;
      lat = 1;
      n = 0;
      while (!rd_ack && n < 40) begin
         @(negedge clk);
         lat++;
         n++;
      end
      resp = rd_data;
      chk("no_bypass", {64'h0, wr_ack}, 65'h0);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   logic [64:0] resp;
   int          lat;
   int          n;

   initial begin
      reset   = 1'b1;
      wr_req  = 1'b0;
      wr_data = '0;
      rd_req  = 1'b0;
      #2;
      chk("rst_wack", {64'h0, wr_ack}, 65'h1);
      chk("rst_rack", {64'h0, rd_ack}, 65'h0);
      chk("rst_rdata", rd_data, 65'h0);
      chk("rst_errcnt", {57'h0, err_count}, 65'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      do_req(1'b0, 8'hFF, 36'h10, W1, 1'b0, resp, lat);
      chk("wr_full_lat", 65'(lat), 65'd3);
      chk("wr_full_rsp", resp, 65'h0);
      do_req(1'b1, 8'h00, 36'h10, 64'h0, 1'b0, resp, lat);
      chk("rd_full_lat", 65'(lat), 65'd3);
      chk("rd_full_rsp", resp, {1'b0, W1});

      do_req(1'b0, 8'h01, 36'h10, 64'hFF, 1'b1, resp, lat);
      chk("wr_b0_rsp", resp, 65'h0);
      do_req(1'b1, 8'h5A, 36'h10, 64'h0, 1'b0, resp, lat);
      chk("rd_b0_rsp", resp, {1'b0, W2});

      do_req(1'b0, 8'h00, 36'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             resp, lat);
      chk("wr_m0_rsp", resp, 65'h0);
      do_req(1'b1, 8'hFF, 36'h17, 64'h0, 1'b0, resp, lat);
      chk("rd_m0_lowbits", resp, {1'b0, W2});

      do_req(1'b1, 8'hFF, 36'h800, 64'h0, 1'b0, resp, lat);
      chk("err_rd_rsp", resp, {1'b1, 64'h0});
      chk("err_rd_lat", 65'(lat), 65'd3);
      chk("err_cnt1", {57'h0, err_count}, 65'd1);
      do_req(1'b0, 8'hFF, 36'h810, 64'h0, 1'b0, resp, lat);
      chk("err_wr_rsp", resp, {1'b1, 64'h0});
      chk("err_cnt2", {57'h0, err_count}, 65'd2);
      do_req(1'b1, 8'hFF, 36'h10, 64'h0, 1'b0, resp, lat);
      chk("err_no_mod", resp, {1'b0, W2});

      do_req(1'b0, 8'hFF, 36'h7FF, W4, 1'b0, resp, lat);
      chk("top_wr_rsp", resp, 65'h0);
      do_req(1'b1, 8'h00, 36'h7F8, 64'h0, 1'b0, resp, lat);
      chk("top_rd_rsp", resp, {1'b0, W4});

      // Response held back while a second request waits.
      @(negedge clk);
      wr_req  = 1'b1;
      wr_data = {1'b0, 1'b1, 8'hFF, 36'h10, 64'h0};
      @(negedge clk);
      wr_data = {1'b1, 1'b0, 8'hFF, 36'h20, W3};
      n = 0;
      while (!rd_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("hold_lat", 65'(n), 65'd2);
      for (int i = 0; i < 10; i++) begin
         chk("hold_rack", {64'h0, rd_ack}, 65'h1);
         chk("hold_rdata", rd_data, {1'b0, W2});
         chk("hold_wack", {64'h0, wr_ack}, 65'h0);
         @(negedge clk);
      end
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      chk("hold_idle_wack", {64'h0, wr_ack}, 65'h1);
      @(negedge clk);
      wr_req = 1'b0;
      chk("second_busy", {64'h0, wr_ack}, 65'h0);
      n = 0;
      while (!rd_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("second_lat", 65'(n), 65'd2);
      chk("second_rsp", rd_data, 65'h0);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      do_req(1'b1, 8'hFF, 36'h20, 64'h0, 1'b0, resp, lat);
      chk("second_rd", resp, {1'b0, W3});

      // Reset in the second ACCESS cycle of a write.
      @(negedge clk);
      wr_req  = 1'b1;
      wr_data = {1'b0, 1'b0, 8'hFF, 36'h10, 64'hDEADBEEF0BADF00D};
      @(negedge clk);
      wr_req = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort_wack", {64'h0, wr_ack}, 65'h1);
      chk("abort_rack", {64'h0, rd_ack}, 65'h0);
      chk("abort_rdata", rd_data, 65'h0);
      chk("abort_errcnt", {57'h0, err_count}, 65'h0);
      @(negedge clk);
      reset = 1'b0;
      do_req(1'b1, 8'hFF, 36'h10, 64'h0, 1'b0, resp, lat);
      chk("abort_old_word", resp, {1'b0, W2});

      for (int i = 0; i < 256; i++) begin
         do_req(1'b1, 8'h00, 36'hF_0000_0000, 64'h0, 1'b0, resp, lat);
      end
      chk("sat_rsp", resp, {1'b1, 64'h0});
      chk("sat_errcnt", {57'h0, err_count}, 65'hFF);
      do_req(1'b1, 8'h00, 36'h20, 64'h0, 1'b0, resp, lat);
      chk("sat_hold", {57'h0, err_count}, 65'hFF);
      chk("sat_rd_ok", resp, {1'b0, W3});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acb_mem_responder.md
ACB_MEM_RESPONDER -- requirements
Module: acb_mem_responder

Interface
REQ-001 Parameter MEM_ADDR_W, default 8: the memory holds 2^MEM_ADDR_W 64-bit words.
REQ-002 Parameter ACCESS_LATENCY, default 2: number of wait-state cycles per access, legal range 1..15.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ACB_MEM_REQUEST_pipe_write_req  in  1  accelerator has a request valid.
REQ-007 ACB_MEM_REQUEST_pipe_write_ack  out  1  responder accepts the request.
REQ-008 ACB_MEM_REQUEST_pipe_write_data  in  110  request fields: [109] lock, [108] read(1)/write(0), [107:100] byte mask, [99:64] 36-bit byte address, [63:0] write data.
REQ-009 ACB_MEM_RESPONSE_pipe_read_req  in  1  accelerator is ready for a response.
REQ-010 ACB_MEM_RESPONSE_pipe_read_ack  out  1  response valid.
REQ-011 ACB_MEM_RESPONSE_pipe_read_data  out  65  response fields: [64] error, [63:0] read data.
REQ-012 err_count  out  8  saturating count of error responses.

Function
REQ-013 Transfer rule: a transfer SHALL occur on any cycle where req and ack are both 1; ack SHALL NOT depend combinationally on req.
REQ-014 FSM states: IDLE, ACCESS, RESPOND.
REQ-015 IDLE: request ack = 1. A transfer SHALL latch the request and move to ACCESS.
REQ-016 ACCESS: lasts exactly ACCESS_LATENCY cycles, timed by a 4-bit down-counter; request ack = 0.
REQ-017 In the last ACCESS cycle the block SHALL perform the memory operation, register the response, and move to RESPOND.
REQ-018 Latency: request accepted in cycle T means response ack = 1 first in cycle T+1+ACCESS_LATENCY.
REQ-019 RESPOND: response ack = 1 and response data held stable until a response transfer; then go to IDLE.
REQ-020 No bypass: request ack SHALL be 0 in the cycle of a response transfer. Minimum spacing between accepted requests is ACCESS_LATENCY+2 cycles.
REQ-021 Word index = address[MEM_ADDR_W+2:3]; address[2:0] is ignored.
REQ-022 Error condition: address[35:MEM_ADDR_W+3] is nonzero.
REQ-023 Read, no error: response data = the full stored 64-bit word regardless of byte mask; error bit = 0.
REQ-024 Write, no error: for each set mask bit i, store byte write_data[8i+7:8i] into word bits [8i+7:8i]; other bytes unchanged; response data = 0; error bit = 0.
REQ-025 Write with mask 0x00: SHALL not modify the word and SHALL still return a normal response.
REQ-026 Error case: no memory modification; response = {1'b1, 64'h0}; err_count increments, saturating at 255.
REQ-027 The lock bit SHALL be accepted and otherwise ignored.
REQ-028 The request pipe SHALL be ignored outside IDLE, even if req is held high.

Reset
REQ-029 On reset assertion, immediately and asynchronously: FSM = IDLE, counter = 0, request ack = 1 (IDLE decode), response ack = 0, response data = 0, err_count = 0.
REQ-030 Memory array contents SHALL NOT be reset.
REQ-031 Reset during ACCESS SHALL abort the operation with no memory write.
REQ-032 Reset during RESPOND SHALL drop the pending response.

Structure
REQ-033 Shared package acb_pkg SHALL hold the request/response widths (110, 65), field bit positions, and the FSM state type.
REQ-034 Sub-module acb_mem_array SHALL implement the byte-enabled synchronous 64-bit RAM (one port, write mask, registered read).

Verification
REQ-035 Reset, then write addr 0x0_0000_0010, mask 0xFF, data 0x1122334455667788 -> response ack in cycle T+3 with data {0, 64'h0}.
REQ-036 Read of addr 0x10 after REQ-035 -> response 0x1122334455667788, error 0.
REQ-037 Write addr 0x10, mask 0x01, data 0xFF -> subsequent read returns 0x11223344556677FF.
REQ-038 Read addr 0x0_0000_0800 (MEM_ADDR_W=8) -> response {1, 64'h0}, err_count = 1, memory unchanged.
REQ-039 Response read_req held 0 for 10 cycles -> response ack and data stable throughout; request ack = 0; a second request is accepted only after the response transfer.
REQ-040 Assert reset in the second ACCESS cycle of a write -> outputs reach reset values; a later read shows the old word.
